pep_ks_loop_sched: RTL and testbench

- Sequences the key-switch MAC array (LBX output columns x LBY BLWE coefficients x LBZ decomposition levels per cycle) for one batch.
- Accepts a batch start command and walks the (column block, coefficient chunk) loop.
- Emits one datapath command per tile, with first/last flags and a column-valid mask.
- Throttles issue with an outstanding-credit counter fed by datapath acknowledges; signals batch completion once every tile is acknowledged.

---
 rtl/pep_ks_loop_sched.sv | 151 +++++++++++++++
 tb/tb_pep_ks_loop_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pep_ks_loop_sched.sv
// pep_ks_loop_sched: walks the (column block, coefficient chunk) tile loop of one key-switch
// batch, issues one MAC-array command per tile and throttles issue with an ack-fed credit count.
module pep_ks_loop_sched #(
    parameter int unsigned LBX        = 6,
    parameter int unsigned LBY        = 64,
    parameter int unsigned LBZ        = 3,
    parameter int unsigned BLWE_K     = 2048,
    parameter int unsigned LWE_K      = 630,
    parameter int unsigned OUTSTD_MAX = 8,
    parameter int unsigned PBS_ID_W   = 6,
    localparam int unsigned X_NB      = (LWE_K + 1 + LBX - 1) / LBX,
    localparam int unsigned Y_NB      = (BLWE_K + LBY - 1) / LBY,
    localparam int unsigned X_W       = (X_NB > 1) ? $clog2(X_NB) : 1,
    localparam int unsigned Y_W       = (Y_NB > 1) ? $clog2(Y_NB) : 1,
    localparam int unsigned Z_W       = $clog2(LBZ + 1)
) (
    input  logic                clk,
    input  logic                s_rst,
    input  logic                batch_vld,
    output logic                batch_rdy,
    input  logic [PBS_ID_W-1:0] batch_id,
    output logic                cmd_vld,
    input  logic                cmd_rdy,
    output logic [X_W-1:0]      cmd_x_idx,
    output logic [Y_W-1:0]      cmd_y_idx,
    output logic                cmd_first_y,
    output logic                cmd_last_y,
    output logic                cmd_last,
    output logic [LBX-1:0]      cmd_x_mask,
    output logic [Z_W-1:0]      cmd_lvl_nb,
    output logic [PBS_ID_W-1:0] cmd_id,
    input  logic                proc_ack,
    output logic                done,
    output logic [PBS_ID_W-1:0] done_id,
    output logic                busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned O_W       = $clog2(OUTSTD_MAX + 1);
    // Columns actually used in the final block (body coefficient included).
    localparam int unsigned LAST_COLS = LWE_K + 1 - (X_NB - 1) * LBX;
    localparam logic [LBX-1:0] LAST_MASK = {LBX{1'b1}} >> (LBX - LAST_COLS);

    logic [1:0]          state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [PBS_ID_W-1:0] id_q, id_d;
    logic [O_W-1:0]      outstd_q, outstd_d;
    logic                cmd_vld_q, cmd_vld_d;
    logic                cmd_hs, ack_eff, at_last_x, at_last_y, in_run;

    // Credit counter: +1 per issued tile, -1 per ack; an ack with nothing outstanding is dropped.
    always_comb begin
        cmd_hs    = cmd_vld_q && cmd_rdy;
        ack_eff   = proc_ack && (outstd_q != '0);
        at_last_x = (x_q == X_W'(X_NB - 1));
        at_last_y = (y_q == Y_W'(Y_NB - 1));
        outstd_d  = outstd_q;
        unique case ({cmd_hs, ack_eff})
            2'b10:   outstd_d = outstd_q + O_W'(1);
            2'b01:   outstd_d = outstd_q - O_W'(1);
            default: outstd_d = outstd_q;
        endcase
    end

    // FSM and tile loop walk (y fastest); cmd_vld is precomputed from next-cycle credit.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        id_d    = id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (batch_vld) begin
                    state_d = ST_RUN;
                    id_d    = batch_id;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ST_RUN: begin
                if (cmd_hs) begin
                    if (at_last_y) begin
                        y_d = '0;
                        if (at_last_x) begin
                            x_d     = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            x_d = x_q + X_W'(1);
                        end
                    end else begin
                        y_d = y_q + Y_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Covers both "already zero" and "last ack arriving now".
                if (outstd_d == '0) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_vld_d = (state_d == ST_RUN) && (outstd_d < O_W'(OUTSTD_MAX));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            id_q      <= '0;
            outstd_q  <= '0;
            cmd_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            id_q      <= id_d;
            outstd_q  <= outstd_d;
            cmd_vld_q <= cmd_vld_d;
        end
    end

    // Outputs; tile flags and mask are only meaningful (non-zero) while running.
    always_comb begin
        in_run      = (state_q == ST_RUN);
        batch_rdy   = (state_q == ST_IDLE);
        busy        = (state_q != ST_IDLE);
        cmd_vld     = cmd_vld_q;
        cmd_x_idx   = x_q;
        cmd_y_idx   = y_q;
        cmd_first_y = in_run && (y_q == '0);
        cmd_last_y  = in_run && at_last_y;
        cmd_last    = in_run && at_last_x && at_last_y;
        cmd_x_mask  = '0;
        if (in_run) cmd_x_mask = at_last_x ? LAST_MASK : '1;
        cmd_lvl_nb  = Z_W'(LBZ);
        cmd_id      = id_q;
        done        = (state_q == ST_DONE);
        done_id     = (state_q == ST_DONE) ? id_q : '0;
    end

    // Acks must never exceed issued commands.
    ack_underflow: assert property (@(posedge clk) disable iff (s_rst)
        !(proc_ack && (outstd_q == '0)));

endmodule

// File: tb/tb_pep_ks_loop_sched.sv
// Bench for pep_ks_loop_sched: small configuration (3x2 tiles, 2 credits) and default one.
`timescale 1ns/1ps
module tb_pep_ks_loop_sched;

    localparam int A_LBX   = 6;
    localparam int A_LWE_K = 13;
    localparam int A_BLWEK = 128;
    localparam int A_OM    = 2;
    localparam int A_XNB   = (A_LWE_K + 1 + A_LBX - 1) / A_LBX;
    localparam int A_YNB   = (A_BLWEK + 64 - 1) / 64;
    localparam int A_TOT   = A_XNB * A_YNB;
    localparam int A_XW    = (A_XNB > 1) ? $clog2(A_XNB) : 1;
    localparam int A_YW    = (A_YNB > 1) ? $clog2(A_YNB) : 1;

    localparam int B_XNB   = (630 + 1 + 6 - 1) / 6;
    localparam int B_YNB   = (2048 + 64 - 1) / 64;
    localparam int B_TOT   = B_XNB * B_YNB;
    localparam int B_XW    = $clog2(B_XNB);
    localparam int B_YW    = $clog2(B_YNB);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic            a_rst, a_bvld, a_brdy, a_cvld, a_crdy, a_fy, a_ly, a_last, a_ack, a_done;
    logic            a_busy;
    logic [5:0]      a_bid, a_mask, a_cid, a_did;
    logic [A_XW-1:0] a_x;
    logic [A_YW-1:0] a_y;
    logic [1:0]      a_lvl;

    logic            b_rst, b_bvld, b_brdy, b_cvld, b_crdy, b_fy, b_ly, b_last, b_ack, b_done;
    logic            b_busy;
    logic [5:0]      b_bid, b_mask, b_cid, b_did;
    logic [B_XW-1:0] b_x;
    logic [B_YW-1:0] b_y;
    logic [1:0]      b_lvl;

    pep_ks_loop_sched #(
        .LBX(A_LBX), .LBY(64), .LBZ(3), .BLWE_K(A_BLWEK), .LWE_K(A_LWE_K),
        .OUTSTD_MAX(A_OM), .PBS_ID_W(6)
    ) dut_a (
        .clk(clk), .s_rst(a_rst), .batch_vld(a_bvld), .batch_rdy(a_brdy), .batch_id(a_bid),
        .cmd_vld(a_cvld), .cmd_rdy(a_crdy), .cmd_x_idx(a_x), .cmd_y_idx(a_y),
        .cmd_first_y(a_fy), .cmd_last_y(a_ly), .cmd_last(a_last), .cmd_x_mask(a_mask),
        .cmd_lvl_nb(a_lvl), .cmd_id(a_cid), .proc_ack(a_ack), .done(a_done),
        .done_id(a_did), .busy(a_busy)
    );

    pep_ks_loop_sched dut_b (
        .clk(clk), .s_rst(b_rst), .batch_vld(b_bvld), .batch_rdy(b_brdy), .batch_id(b_bid),
        .cmd_vld(b_cvld), .cmd_rdy(b_crdy), .cmd_x_idx(b_x), .cmd_y_idx(b_y),
        .cmd_first_y(b_fy), .cmd_last_y(b_ly), .cmd_last(b_last), .cmd_x_mask(b_mask),
        .cmd_lvl_nb(b_lvl), .cmd_id(b_cid), .proc_ack(b_ack), .done(b_done),
        .done_id(b_did), .busy(b_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of the full-throughput 3x2 batch: stimulus to drive and outputs to expect.
    typedef struct {
        logic       rdy, ack;
        logic       vld;
        logic [1:0] x;
        logic       y, fy, ly, last;
        logic [5:0] mask;
        logic       done, busy, brdy;
        logic [5:0] did;
    } vec_t;

    function automatic vec_t mk(int rdy, int ack, int vld, int x, int y, int fy, int ly,
                                int last, int mask, int dn, int bsy, int brdy, int did);
        vec_t v;
        v.rdy = rdy[0]; v.ack = ack[0]; v.vld = vld[0]; v.x = 2'(x); v.y = y[0];
        v.fy = fy[0]; v.ly = ly[0]; v.last = last[0]; v.mask = 6'(mask);
        v.done = dn[0]; v.busy = bsy[0]; v.brdy = brdy[0]; v.did = 6'(did);
        return v;
    endfunction

    // Randomised batch on dut_a checked against a tile-counting model.
    task automatic run_a(input logic [5:0] id, input int unsigned rdy_pct,
                         input int unsigned ack_pct);
        int out = 0, issued = 0, done_seen = 0, cyc = 0, ex, ey, cols;
        bit draining = 0, exp_done = 0, hs, ack, rdy, stalled = 0;
        logic [A_XW+A_YW+8:0] prev = '0, cur, exp;
        check("run_start_rdy", a_brdy, 1);
        a_bvld = 1'b1; a_bid = id;
        tick();
        a_bvld = 1'b0;
        while (done_seen == 0 && cyc < 400) begin
            cyc++;
            cur = {a_x, a_y, a_fy, a_ly, a_last, a_mask};
            check("run_done", a_done, exp_done);
            if (a_done) begin
                done_seen++;
                check("run_done_id", a_did, id);
            end else begin
                check("run_vld", a_cvld, (issued < A_TOT) && (out < A_OM));
                if (stalled) check("run_stall_hold", cur, prev);
                rdy = ($urandom_range(99) < rdy_pct);
                ack = (out > 0) && ($urandom_range(99) < ack_pct);
                hs  = a_cvld && rdy;
                if (hs) begin
                    ex   = issued / A_YNB;
                    ey   = issued % A_YNB;
                    cols = A_LWE_K + 1 - ex * A_LBX;
                    if (cols > A_LBX) cols = A_LBX;
                    exp = {A_XW'(ex), A_YW'(ey), ey == 0, ey == A_YNB - 1,
                           issued == A_TOT - 1, 6'((1 << cols) - 1)};
                    check("run_tile", cur, exp);
                    check("run_cmd_id", a_cid, id);
                    issued++;
                end
                stalled = a_cvld && !rdy;
                prev    = cur;
                a_crdy  = rdy;
                a_ack   = ack;
                tick();
                out      = out + int'(hs) - int'(ack);
                exp_done = draining && (out == 0);
                if (exp_done) draining = 0;
                if (hs && issued == A_TOT) draining = 1;
            end
        end
        a_crdy = 1'b0;
        a_ack  = 1'b0;
        check("run_done_once", done_seen, 1);
        check("run_count", issued, A_TOT);
        tick();
        check("run_idle_after", {a_done, a_busy, a_brdy}, 3'b001);
    endtask

    initial begin
        vec_t tbl[9];
        int   hs_cnt, got;

        tbl[0] = mk(1, 0, 1, 0, 0, 1, 0, 0, 'h3F, 0, 1, 0, 0);
        tbl[1] = mk(1, 1, 1, 0, 1, 0, 1, 0, 'h3F, 0, 1, 0, 0);
        tbl[2] = mk(1, 1, 1, 1, 0, 1, 0, 0, 'h3F, 0, 1, 0, 0);
        tbl[3] = mk(1, 1, 1, 1, 1, 0, 1, 0, 'h3F, 0, 1, 0, 0);
        tbl[4] = mk(1, 1, 1, 2, 0, 1, 0, 0, 'h03, 0, 1, 0, 0);
        tbl[5] = mk(1, 1, 1, 2, 1, 0, 1, 1, 'h03, 0, 1, 0, 0);
        tbl[6] = mk(1, 1, 0, 0, 0, 0, 0, 0, 'h00, 0, 1, 0, 0);
        tbl[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h00, 1, 1, 0, 'h2A);
        tbl[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0, 0, 1, 0);

        a_rst = 1'b1; a_bvld = 1'b0; a_bid = '0; a_crdy = 1'b0; a_ack = 1'b0;
        b_rst = 1'b1; b_bvld = 1'b0; b_bid = '0; b_crdy = 1'b0; b_ack = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_a_ctrl", {a_brdy, a_cvld, a_done, a_busy, a_fy, a_ly, a_last}, 7'b1000000);
        check("rst_a_data", {a_x, a_y, a_mask, a_cid, a_did}, '0);
        check("rst_b_ctrl", {b_brdy, b_cvld, b_done, b_busy, b_fy, b_ly, b_last}, 7'b1000000);
        check("rst_b_data", {b_x, b_y, b_mask, b_cid, b_did}, '0);
        a_rst = 1'b0; b_rst = 1'b0;
        tick();

        // Full-throughput batch, acks one cycle after each handshake.
        check("tbl_start_rdy", a_brdy, 1);
        a_bvld = 1'b1; a_bid = 6'h2A;
        tick();
        a_bvld = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("tbl%0d_ctrl", i),
                  {a_cvld, a_fy, a_ly, a_last, a_done, a_busy, a_brdy},
                  {tbl[i].vld, tbl[i].fy, tbl[i].ly, tbl[i].last, tbl[i].done, tbl[i].busy,
                   tbl[i].brdy});
            check($sformatf("tbl%0d_mask", i), a_mask, tbl[i].mask);
            check($sformatf("tbl%0d_did", i), a_did, tbl[i].did);
            if (tbl[i].vld) begin
                check($sformatf("tbl%0d_xy", i), {a_x, a_y}, {tbl[i].x, tbl[i].y});
                check($sformatf("tbl%0d_id", i), {a_cid, a_lvl}, {6'h2A, 2'd3});
            end
            a_crdy = tbl[i].rdy;
            a_ack  = tbl[i].ack;
            tick();
        end

        // Credit exhaustion: two commands only, then one ack releases one more.
        check("thr_start_rdy", a_brdy, 1);
        a_bvld = 1'b1; a_bid = 6'h05;
        tick();
        a_bvld = 1'b0; a_crdy = 1'b1;
        hs_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (a_cvld && a_crdy) hs_cnt++;
            tick();
        end
        check("thr_issued", hs_cnt, 2);
        check("thr_blocked", a_cvld, 0);
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        got = 0;
        for (int k = 0; k < 2; k++) begin
            if (a_cvld) begin
                got = 1;
                break;
            end
            tick();
        end
        check("thr_resume", got, 1);
        check("thr_third_tile", {a_x, a_y}, {2'd1, 1'b0});
        tick();
        // Third command taken; reset mid-batch with two acks still pending.
        a_crdy = 1'b0;
        a_rst  = 1'b1;
        tick();
        a_rst = 1'b0;
        check("midrst_ctrl", {a_cvld, a_busy, a_brdy, a_done}, 4'b0010);
        check("midrst_data", {a_x, a_y, a_mask}, '0);

        // Restart from (0,0), back-to-back batches, then random backpressure and acks.
        run_a(6'h07, 100, 100);
        run_a(6'h15, 50, 50);
        run_a(6'h3C, 70, 20);
        run_a(6'h01, 50, 90);

        // Default configuration: full walk of 106x32 tiles.
        begin
            int   issued = 0, out = 0, dn = 0, cyc = 0, ex, ey, cols;
            bit   hs, ack_next = 0;
            logic [5:0] last_mask = '0;
            logic [B_XW+B_YW+8:0] cur, exp;
            check("dflt_start_rdy", b_brdy, 1);
            b_crdy = 1'b1; b_bvld = 1'b1; b_bid = 6'h11;
            tick();
            b_bvld = 1'b0;
            while (dn == 0 && cyc < 5000) begin
                cyc++;
                if (b_done) begin
                    dn++;
                    check("dflt_done_id", b_did, 6'h11);
                    check("dflt_done_after_acks", out, 0);
                end else begin
                    hs = b_cvld;
                    if (hs) begin
                        ex   = issued / B_YNB;
                        ey   = issued % B_YNB;
                        cols = 631 - ex * 6;
                        if (cols > 6) cols = 6;
                        cur = {b_x, b_y, b_fy, b_ly, b_last, b_mask};
                        exp = {B_XW'(ex), B_YW'(ey), ey == 0, ey == B_YNB - 1,
                               issued == B_TOT - 1, 6'((1 << cols) - 1)};
                        check("dflt_tile", cur, exp);
                        if (issued == B_TOT - 1) last_mask = b_mask;
                        issued++;
                    end
                    b_ack    = ack_next;
                    out      = out + int'(hs) - int'(ack_next);
                    ack_next = hs;
                    tick();
                end
            end
            b_ack = 1'b0;
            check("dflt_count", issued, 3392);
            check("dflt_last_mask", last_mask, 6'b000001);
            check("dflt_done_once", dn, 1);
            check("dflt_lvl", b_lvl, 2'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
